// File: rtl/lector_segmentos.sv
// Recovers hex digits from a time-multiplexed 7-segment display bus and publishes full frames.
// Optional macro SEG_ERR_COUNT_EN adds a saturating count of unrecognized captures (err_count).
module lector_segmentos #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] valor,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
`ifdef SEG_ERR_COUNT_EN
    output logic [7:0]              err_count,
`endif
    output logic                    frame_valid
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // {blank, err, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = 6'h00;
            7'h30: decode = 6'h01;
            7'h6D: decode = 6'h02;
            7'h79: decode = 6'h03;
            7'h33: decode = 6'h04;
            7'h5B: decode = 6'h05;
            7'h5F: decode = 6'h06;
            7'h70: decode = 6'h07;
            7'h7F: decode = 6'h08;
            7'h7B: decode = 6'h09;
            7'h77: decode = 6'h0A;
            7'h1F: decode = 6'h0B;
            7'h4E: decode = 6'h0C;
            7'h3D: decode = 6'h0D;
            7'h4F: decode = 6'h0E;
            7'h47: decode = 6'h0F;
            7'h00: decode = 6'b10_0000;
            default: decode = 6'b01_0000;
        endcase
    endfunction

    logic [6:0]            seg_m, seg_s;
    logic [NUM_DIGITS-1:0] en_m, en_s;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [6:0]            lat_seg, lat_seg_nxt;
    logic [NUM_DIGITS-1:0] lat_en, lat_en_nxt;
    logic                  capture, start;

    logic [NUM_DIGITS-1:0]        captured;
    logic [NUM_DIGITS-1:0][3:0]   stg_val;
    logic [NUM_DIGITS-1:0]        stg_blank, stg_err;

    logic       onehot, pair_eq, frame_done;
    logic [5:0] dec;

    assign onehot     = $onehot(en_s);
    assign pair_eq    = (seg_s == lat_seg) && (en_s == lat_en);
    assign frame_done = &captured;
    assign dec        = decode(seg_s);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_seg_nxt = lat_seg;
        lat_en_nxt  = lat_en;
        capture     = 1'b0;
        start       = 1'b0;
        case (state)
            IDLE:   start = onehot;
            SETTLE: begin
                if (!onehot) begin
                    state_nxt = IDLE;
                end else if (pair_eq) begin
                    if (cnt >= CNT_LAST) begin
                        capture   = 1'b1;
                        cnt_nxt   = CNT_MAX;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    start = 1'b1;
                end
            end
            HOLD: begin
                if (!pair_eq) begin
                    state_nxt = IDLE;
                    start     = onehot;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A fresh one-hot pair counts as its first settled sample.
        if (start) begin
            lat_seg_nxt = seg_s;
            lat_en_nxt  = en_s;
            if (SETTLE_CYCLES == 1) begin
                capture   = 1'b1;
                cnt_nxt   = CNT_MAX;
                state_nxt = HOLD;
            end else begin
                cnt_nxt   = CNT_ONE;
                state_nxt = SETTLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m   <= '0;
            seg_s   <= '0;
            en_m    <= '0;
            en_s    <= '0;
            state   <= IDLE;
            cnt     <= '0;
            lat_seg <= '0;
            lat_en  <= '0;
        end else begin
            seg_m   <= seg;
            seg_s   <= seg_m;
            en_m    <= digit_en;
            en_s    <= en_m;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            lat_seg <= lat_seg_nxt;
            lat_en  <= lat_en_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured    <= '0;
            stg_val     <= '0;
            stg_blank   <= '0;
            stg_err     <= '0;
            valor       <= '0;
            blank       <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                valor <= stg_val;
                blank <= stg_blank;
                err   <= stg_err;
            end
            // A capture landing on the publish cycle seeds the next frame's mask.
            captured <= (frame_done ? '0 : captured) | (capture ? en_s : '0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && en_s[i]) begin
                    stg_val[i]   <= dec[3:0];
                    stg_err[i]   <= dec[4];
                    stg_blank[i] <= dec[5];
                end
            end
        end
    end

`ifdef SEG_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (capture && dec[4] && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_lector_segmentos.sv
// Randomized + directed bench for lector_segmentos; a run-length reference model feeds a frame scoreboard.
module tb_lector_segmentos;

    localparam int ND = 4;
    localparam int S  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    seg = '0;
    logic [ND-1:0] digit_en = '0;
    logic [4*ND-1:0] valor;
    logic [ND-1:0] blank, err;
    logic          frame_valid;
`ifdef SEG_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif

    always #5 clk = ~clk;

    lector_segmentos #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .digit_en(digit_en),
        .valor(valor), .blank(blank), .err(err),
`ifdef SEG_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .frame_valid(frame_valid)
    );

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  e;
    } frame_t;

    frame_t exp_q[$];
    int n_pass = 0, n_total = 0, n_frames = 0;

    // Reference model: a digit is captured when the same one-hot (seg, en) pair has been
    // presented for exactly S consecutive cycles; a full mask publishes on the next cycle.
    logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int         m_run;
    logic [6:0] m_pseg;
    logic [3:0] m_pen, m_mask, m_b, m_e;
    logic [3:0] m_v [4];
    int         m_ecount;

    task automatic model_reset();
        m_run = 0; m_pseg = '0; m_pen = '0; m_mask = '0; m_b = '0; m_e = '0;
        for (int i = 0; i < 4; i++) m_v[i] = '0;
        m_ecount = 0;
    endtask

    task automatic model_step(input logic [6:0] s, input logic [3:0] e);
        bit oh;
        int idx, hit;
        frame_t f;
        if (m_mask == 4'hF) begin
            f.v = {m_v[3], m_v[2], m_v[1], m_v[0]};
            f.b = m_b;
            f.e = m_e;
            exp_q.push_back(f);
            m_mask = '0;
        end
        oh = (e != 0) && ((e & (e - 4'd1)) == 0);
        if (oh && m_run > 0 && s == m_pseg && e == m_pen) m_run++;
        else if (oh) m_run = 1;
        else m_run = 0;
        m_pseg = s;
        m_pen  = e;
        if (m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (e[i]) idx = i;
            hit = -1;
            for (int k = 0; k < 16; k++) if (tbl[k] == s) hit = k;
            m_b[idx] = (s == 7'h00);
            m_e[idx] = (s != 7'h00) && (hit < 0);
            m_v[idx] = (hit < 0) ? 4'h0 : 4'(hit);
            if (m_e[idx] && m_ecount < 255) m_ecount++;
            m_mask = m_mask | e;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    endtask

    task automatic step(input logic [6:0] s, input logic [3:0] e);
        seg = s;
        digit_en = e;
        model_step(s, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(7'h00, 4'h0);
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3, input int hold);
        logic [6:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        for (int d = 0; d < 4; d++)
            for (int c = 0; c < hold; c++) step(p[d], 4'(1 << d));
    endtask

    task automatic pulse_reset();
        seg = '0;
        digit_en = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic monitor();
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst_n && frame_valid) begin
                n_frames++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'(frame_valid), 32'h0);
                end else begin
                    f = exp_q.pop_front();
                    chk("frame_valor", 32'(valor), 32'(f.v));
                    chk("frame_blank", 32'(blank), 32'(f.b));
                    chk("frame_err", 32'(err), 32'(f.e));
                end
            end
        end
    endtask

    task automatic stimulus();
        int f0;
        logic [6:0] p;
        logic [3:0] e;
        int hold;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valor", 32'(valor), 32'h0);
        chk("reset_blank", 32'(blank), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1;

        // basic scan
        f0 = n_frames;
        scan(7'h79, 7'h30, 7'h5B, 7'h7F, 8);
        idle(6);
        chk("scan1_frames", 32'(n_frames - f0), 32'd1);
        chk("scan1_valor", 32'(valor), 32'h8513);
        chk("scan1_blank", 32'(blank), 32'h0);
        chk("scan1_err", 32'(err), 32'h0);

        // blank on digit 2, unrecognized on digit 1
        f0 = n_frames;
        scan(7'h79, 7'h12, 7'h00, 7'h7F, 8);
        idle(6);
        chk("blankerr_frames", 32'(n_frames - f0), 32'd1);
        chk("blankerr_blank", 32'(blank), 32'b0100);
        chk("blankerr_err", 32'(err), 32'b0010);
        chk("blankerr_valor", 32'(valor), 32'h8003);

        // too short to settle, then just long enough
        f0 = n_frames;
        scan(7'h30, 7'h6D, 7'h79, 7'h33, 2);
        idle(6);
        chk("short_hold_frames", 32'(n_frames - f0), 32'd0);
        scan(7'h30, 7'h6D, 7'h79, 7'h33, 3);
        idle(6);
        chk("exact_hold_frames", 32'(n_frames - f0), 32'd1);
        chk("exact_hold_valor", 32'(valor), 32'h4321);

        // multi-hot enable mid-scan
        f0 = n_frames;
        for (int c = 0; c < 8; c++) step(7'h5F, 4'b0001);
        for (int c = 0; c < 10; c++) step(7'h70, 4'b0011);
        for (int c = 0; c < 8; c++) step(7'h70, 4'b0010);
        for (int c = 0; c < 8; c++) step(7'h7B, 4'b0100);
        for (int c = 0; c < 8; c++) step(7'h77, 4'b1000);
        idle(6);
        chk("multihot_frames", 32'(n_frames - f0), 32'd1);
        chk("multihot_valor", 32'(valor), 32'hA976);

        // recapture of digit 0
        f0 = n_frames;
        for (int c = 0; c < 8; c++) step(7'h30, 4'b0001);
        scan(7'h6D, 7'h4E, 7'h3D, 7'h4F, 8);
        idle(6);
        chk("recapture_frames", 32'(n_frames - f0), 32'd1);
        chk("recapture_valor", 32'(valor), 32'hEDC2);

        // reset after a partial scan
        scan(7'h1F, 7'h47, 7'h7E, 7'h00, 8);
        f0 = n_frames;
        exp_q.delete();
        idle(4);
        pulse_reset();
        @(negedge clk);
        chk("midreset_valor", 32'(valor), 32'h0);
        chk("midreset_blank", 32'(blank), 32'h0);
        chk("midreset_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 8; c++) step(7'h7E, 4'b1000);
        idle(6);
        chk("midreset_no_frame", 32'(n_frames - f0), 32'd0);
        scan(7'h1F, 7'h47, 7'h7E, 7'h7E, 8);
        idle(6);
        chk("midreset_next_frames", 32'(n_frames - f0), 32'd1);
        chk("midreset_next_valor", 32'(valor), 32'h00FB);

        // randomized scan traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 16) p = tbl[r];
            else if (r == 16) p = 7'h00;
            else p = 7'($urandom);
            if ($urandom_range(0, 9) == 0) e = 4'($urandom);
            else e = 4'(1 << $urandom_range(0, 3));
            hold = $urandom_range(1, 7);
            for (int c = 0; c < hold; c++) step(p, e);
        end
        idle(8);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEG_ERR_COUNT_EN
        chk("err_count", 32'(err_count), 32'(m_ecount));
`endif
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
